// File: rtl/imem_arbiter.sv
// Round-robin arbiter/sequencer between fetch (port 0) and load/store (port 1) for a shared
// word memory: accept -> ACCESS (memory driven) -> RESP (registered data + per-port strobe).
module imem_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [31:0]       req0_addr,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [31:0]       req1_addr,
  input  logic              req1_we,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                port_q, port_d;
  logic [31:0]         addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic grant0, grant1, in_range;

  // On conflict the port that did not win last time is granted.
  assign grant0   = req0_valid & (~req1_valid | last_grant_q);
  assign grant1   = req1_valid & (~req0_valid | ~last_grant_q);
  assign in_range = (addr_q < 32'(DEPTH));

  assign mem_addr  = addr_q[ADDR_W-1:0];
  assign mem_wdata = wdata_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst_n so no handshake is signalled while reset is held.
        req0_ready = rst_n & grant0;
        req1_ready = rst_n & grant1;
        if (req0_ready) begin
          port_d       = 1'b0;
          addr_d       = req0_addr;
          we_d         = 1'b0;
          wdata_d      = '0;
          last_grant_d = 1'b0;
          state_d      = ACCESS;
        end else if (req1_ready) begin
          port_d       = 1'b1;
          addr_d       = req1_addr;
          we_d         = req1_we;
          wdata_d      = req1_wdata;
          last_grant_d = 1'b1;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        mem_we     = we_q & in_range;
        rsp_data_d = (~we_q & in_range) ? mem_rdata : '0;
        rsp_err_d  = ~in_range;
        state_d    = RESP;
      end
      RESP: begin
        rsp0_valid = ~port_q;
        rsp1_valid = port_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: transaction-level reference model checked every cycle, plus
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_imem_arbiter;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready, req1_we;
  logic [31:0] req0_addr, req1_addr, req1_wdata;
  logic        rsp0_valid, rsp1_valid, rsp_err, mem_we;
  logic [31:0] rsp_data, mem_wdata, mem_rdata;
  logic [6:0]  mem_addr;

  logic [31:0] tb_mem  [128];
  logic [31:0] ref_mem [128];

  int n_chk = 0;
  int n_pass = 0;
  int we_cnt = 0;
  logic [6:0] last_we_addr = '0;

  imem_arbiter #(.DATA_W(32), .DEPTH(128), .ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_we(req1_we), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      we_cnt++;
      last_we_addr = mem_addr;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one outstanding transaction; phase counts cycles since acceptance.
  int          m_phase = 0;
  logic        m_last = 1'b1;
  logic        m_port = 1'b0;
  logic [31:0] m_addr = '0;
  logic        m_we = 1'b0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;

  always @(negedge clk) begin
    logic e0, e1, inr, exp_we;
    if (!rst_n) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp_err, mem_we}, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_maddr", mem_addr, 0);
      chk("rst_mwdata", mem_wdata, 0);
      m_phase = 0;
      m_last  = 1'b1;
    end else begin
      e0 = (m_phase == 0) && req0_valid && (!req1_valid || m_last);
      e1 = (m_phase == 0) && req1_valid && (!req0_valid || !m_last);
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      exp_we = 1'b0;
      if (m_phase == 1) begin
        inr     = (m_addr < 128);
        exp_we  = m_we && inr;
        m_rdata = (!m_we && inr) ? ref_mem[m_addr[6:0]] : 32'h0;
        m_err   = !inr;
        chk("mem_addr", mem_addr, m_addr[6:0]);
        if (exp_we) begin
          chk("mem_wdata", mem_wdata, m_wdata);
          ref_mem[m_addr[6:0]] = m_wdata;
        end
      end
      chk("mem_we", mem_we, exp_we);
      chk("rsp0_valid", rsp0_valid, (m_phase == 2) && !m_port);
      chk("rsp1_valid", rsp1_valid, (m_phase == 2) && m_port);
      if (m_phase == 2) begin
        chk("rsp_data", rsp_data, m_rdata);
        chk("rsp_err", rsp_err, m_err);
      end
      if (m_phase == 0 && (e0 || e1)) begin
        m_port  = e1;
        m_addr  = e0 ? req0_addr : req1_addr;
        m_we    = e0 ? 1'b0 : req1_we;
        m_wdata = req1_wdata;
        m_last  = e1;
        m_phase = 1;
      end else if (m_phase == 1) m_phase = 2;
      else m_phase = 0;
    end
  end

  task automatic do_txn(input bit port, input logic [31:0] addr, input logic we,
                        input logic [31:0] wd, output logic [31:0] d, output logic e);
    int n;
    bit got;
    cyc();
    if (port) begin
      req1_valid = 1'b1; req1_addr = addr; req1_we = we; req1_wdata = wd;
    end else begin
      req0_valid = 1'b1; req0_addr = addr;
    end
    n = 0;
    @(negedge clk);
    while (!(port ? req1_ready : req0_ready) && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("accept_bound", n < 20, 1);
    cyc();
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    got = 1'b0; d = '0; e = 1'b0; n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      if (port ? rsp1_valid : rsp0_valid) begin
        got = 1'b1; d = rsp_data; e = rsp_err;
      end
      n++;
    end
    chk("rsp_bound", got, 1);
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, 127));
    else if (r < 9) return 32'($urandom_range(128, 255));
    else return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic e;
    int wc, ng;
    logic [31:0] d0, d1;
    int gseq [8];

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_we = 1'b0; req1_wdata = '0;
    for (int i = 0; i < 128; i++) begin
      tb_mem[i]  = 32'h1000_0000 + 32'(3 * i);
      ref_mem[i] = 32'h1000_0000 + 32'(3 * i);
    end
    tb_mem[5]  = 32'h8C12_3456;
    ref_mem[5] = 32'h8C12_3456;

    repeat (3) @(posedge clk);
    #1;
    chk("t0_reset_outs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_we, rsp_err}, 0);
    rst_n = 1'b1;

    // Single fetch: ready at T, response at T+2.
    cyc();
    req0_valid = 1'b1; req0_addr = 32'd5;
    @(negedge clk) chk("t1_ready", req0_ready, 1);
    cyc();
    req0_valid = 1'b0;
    @(negedge clk) chk("t1_access_norsp", rsp0_valid, 0);
    cyc();
    @(negedge clk);
    chk("t1_rsp0", rsp0_valid, 1);
    chk("t1_data", rsp_data, 32'h8C12_3456);
    chk("t1_err", rsp_err, 0);

    // Store then load on port 1.
    wc = we_cnt;
    do_txn(1'b1, 32'd9, 1'b1, 32'hAD65_4321, d, e);
    chk("t2_we_once", we_cnt - wc, 1);
    chk("t2_we_addr", last_we_addr, 9);
    chk("t2_store_data", d, 0);
    do_txn(1'b1, 32'd9, 1'b0, 32'h0, d, e);
    chk("t2_load_data", d, 32'hAD65_4321);

    // Out of range store, then load of the aliased word.
    wc = we_cnt;
    do_txn(1'b1, 32'd200, 1'b1, 32'hFFFF_0000, d, e);
    chk("t4_no_we", we_cnt - wc, 0);
    chk("t4_err", e, 1);
    chk("t4_data", d, 0);
    do_txn(1'b1, 32'd72, 1'b0, 32'h0, d, e);
    chk("t4_alias_data", d, 32'h1000_00D8);
    chk("t4_alias_err", e, 0);

    // Backpressure: port 1 waits through ACCESS and RESP of port 0.
    cyc();
    req0_valid = 1'b1; req0_addr = 32'd3;
    @(negedge clk) chk("t6_ready0", req0_ready, 1);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 32'd4; req1_we = 1'b0;
    @(negedge clk) chk("t6_hold_access", req1_ready, 0);
    cyc();
    @(negedge clk);
    chk("t6_hold_resp", req1_ready, 0);
    chk("t6_rsp0_data", rsp_data, 32'h1000_0009);
    cyc();
    @(negedge clk) chk("t6_accept_idle", req1_ready, 1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("t6_rsp1", rsp1_valid, 1);
    chk("t6_rsp1_data", rsp_data, 32'h1000_000C);

    // Reset during ACCESS of a store, then port 0 wins the first conflict.
    wc = we_cnt;
    cyc();
    req1_valid = 1'b1; req1_addr = 32'd20; req1_we = 1'b1; req1_wdata = 32'hDEAD_BEEF;
    @(negedge clk) chk("t5_accept", req1_ready, 1);
    cyc();
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_zero_ctl", {mem_we, rsp0_valid, rsp1_valid, rsp_err}, 0);
    chk("t5_zero_addr", mem_addr, 0);
    chk("t5_zero_wdata", mem_wdata, 0);
    req0_valid = 1'b1; req0_addr = 32'd0;
    req1_valid = 1'b1; req1_addr = 32'd1; req1_we = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_first_conflict0", req0_ready, 1);
    chk("t5_first_conflict1", req1_ready, 0);
    chk("t5_no_write", we_cnt - wc, 0);

    // Contention right after reset: grants alternate 0,1,0,1.
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    ng = 0; d0 = '0; d1 = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready && ng < 8) begin gseq[ng] = 0; ng++; end
      if (req1_ready && ng < 8) begin gseq[ng] = 1; ng++; end
      if (rsp0_valid) d0 = rsp_data;
      if (rsp1_valid) d1 = rsp_data;
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) chk("t3_grant_order", gseq[i], i % 2);
    chk("t3_mem0", d0, 32'h1000_0000);
    chk("t3_mem1", d1, 32'h1000_0003);
    repeat (4) cyc();
    do_txn(1'b0, 32'd20, 1'b0, 32'h0, d, e);
    chk("t5_store_aborted", d, 32'h1000_003C);

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (c % 700 == 350) rst_n = 1'b0;
      if (c % 700 == 352) rst_n = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_addr  = rnd_addr();
      end
      if ($urandom_range(0, 1) == 1) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_addr  = rnd_addr();
        req1_we    = $urandom_range(0, 1) == 1;
        req1_wdata = $urandom;
      end
    end
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 128-word x 32-bit instruction/data memory.
- Port 0 is the fetch unit; port 1 is the load/store unit.
- Serialises accesses with round-robin priority, drives the memory's combinational-read port and returns registered read data with a per-port response strobe.
- Sits between the fetch/mem stages and the memory array.

Parameters:
- DATA_W, 32, word width.
- DEPTH, 128, number of memory words; valid word addresses are 0..DEPTH-1.
- ADDR_W, 7, memory address width (log2 DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  fetch request valid.
- req0_ready  out  1  fetch request accepted this cycle.
- req0_addr  in  32  fetch word address.
- req1_valid  in  1  load/store request valid.
- req1_ready  out  1  load/store request accepted this cycle.
- req1_addr  in  32  load/store word address.
- req1_we  in  1  1 = store, 0 = load.
- req1_wdata  in  DATA_W  store data.
- rsp0_valid  out  1  one-cycle fetch response strobe.
- rsp1_valid  out  1  one-cycle load/store response strobe.
- rsp_data  out  DATA_W  read data for the current response; 0 for stores and errors.
- rsp_err  out  1  response is for an out-of-range address; qualified by rsp0_valid or rsp1_valid.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable, one-cycle pulse.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (async, rst_n low):
  - state = IDLE; last_grant = 1, so port 0 wins the first conflict.
  - All outputs 0: req*_ready, rsp*_valid, rsp_data, rsp_err, mem_addr, mem_we, mem_wdata.
  - Latched request fields cleared.
- IDLE:
  - Readiness: reqN_ready = reqN_valid & granted(N), combinational.
  - Grant when only one port is valid: that port.
  - Grant when both are valid: the port != last_grant.
  - On handshake, latch port id, addr, we (port 0 always load), wdata; update last_grant; go to ACCESS.
  - At most one ready is high per cycle.
- ACCESS:
  - mem_addr = latched addr[ADDR_W-1:0], registered, so valid for the whole ACCESS cycle.
  - mem_we = latched we & in-range; mem_wdata = latched wdata.
  - Capture rsp_data = mem_rdata for an in-range load, else 0.
  - Capture rsp_err = (addr >= DEPTH).
  - Go to RESP.
- RESP:
  - rsp<id>_valid high exactly one cycle; rsp_data and rsp_err held stable during it; mem_we = 0.
  - Next state: IDLE.
  - Both ready outputs are 0 in ACCESS and RESP.
- Latency: handshake in cycle T -> mem_we/mem_addr in T+1 -> rsp valid in T+2. Next handshake is possible at T+3.
- Out-of-range address: no memory write, rsp_data = 0, rsp_err = 1, response still issued.
- Held requests: a request held valid and unaccepted must not be dropped. A requester may deassert valid before acceptance with no effect.
- Reset mid-operation: transaction aborted, no response, no partial write after reset deasserts.
- rsp_data and rsp_err keep their last value outside RESP; they are qualified only by the rsp*_valid strobes.

Test Plan:
- Reset then single fetch:
  - Stimulus: MEM[5] = 0x8C123456; req0_valid with addr 5 at cycle T.
  - Required: req0_ready at T; rsp0_valid at T+2 with rsp_data = 0x8C123456, rsp_err = 0.
- Store then load on port 1:
  - Stimulus: store addr 9, wdata 0xAD654321; then load addr 9.
  - Required: mem_we pulses once with mem_addr = 9; the load returns 0xAD654321; the store response has rsp_data = 0.
- Contention:
  - Stimulus: both ports valid continuously from reset, port 0 addr 0, port 1 addr 1.
  - Required: grants alternate 0,1,0,1; each response lands on the correct rsp*_valid with MEM[0] or MEM[1].
- Out of range:
  - Stimulus: port 1 store to addr 200.
  - Required: mem_we never asserts; rsp1_valid with rsp_err = 1, rsp_data = 0; a later load of addr 200 & 127 = 72 shows unchanged contents.
- Reset mid-operation:
  - Stimulus: assert rst_n low during ACCESS of a store.
  - Required: all outputs 0 immediately; no rsp*_valid; after release, port 0 wins the first conflict.
- Backpressure hold:
  - Stimulus: port 1 valid during port 0's transaction.
  - Required: req1_ready stays 0 through ACCESS and RESP; port 1 is accepted in the first IDLE cycle after RESP.
